// File: rtl/adrctl.sv
// adrctl: four-phase slot address controller arbitrating refresh, video and DMA
// onto one bus address, with per-owner address counters.
`default_nettype none

module adrctl (
  input  logic        c,
  input  logic        xr,
  input  logic        vld,
  input  logic [20:0] vbase,
  input  logic        vreq,
  input  logic        dld,
  input  logic [20:0] dbase,
  input  logic [7:0]  dcnt,
  input  logic        dreq,
  input  logic        refr,
  output logic [20:0] addr,
  output logic        cyc,
  output logic [1:0]  own,
  output logic [20:0] vaddr,
  output logic [20:0] daddr,
  output logic [7:0]  dleft,
  output logic        ddone,
  output logic [7:0]  rcnt
);

  localparam logic [1:0] c_OWN_IDLE = 2'b00;
  localparam logic [1:0] c_OWN_VID  = 2'b01;
  localparam logic [1:0] c_OWN_DMA  = 2'b10;
  localparam logic [1:0] c_OWN_REF  = 2'b11;

  logic [1:0]  r_phase;
  logic [1:0]  r_own;
  logic        r_cyc;
  logic [20:0] r_addr;
  logic [20:0] r_vaddr;
  logic [20:0] r_daddr;
  logic [7:0]  r_dleft;
  logic        r_ddone;
  logic [7:0]  r_rcnt;
  logic        r_rpend;

  logic        w_slot_end;
  logic        w_vinc;
  logic        w_dstep;
  logic        w_rinc;
  logic [20:0] w_vaddr_nxt;
  logic [20:0] w_daddr_nxt;
  logic [7:0]  w_dleft_nxt;
  logic [7:0]  w_rcnt_nxt;
  logic        w_ddone_nxt;
  logic [1:0]  w_own_nxt;
  logic [20:0] w_addr_nxt;

  assign w_slot_end = (r_phase == 2'd3);
  assign w_vinc     = w_slot_end && (r_own == c_OWN_VID);
  assign w_dstep    = w_slot_end && (r_own == c_OWN_DMA);
  assign w_rinc     = w_slot_end && (r_own == c_OWN_REF);

  // Arbitration looks at the post-edge counter values so a back-to-back slot
  // of the same owner already sees the advanced address / remaining count.
  assign w_vaddr_nxt = vld ? vbase : (w_vinc ? r_vaddr + 21'd1 : r_vaddr);
  assign w_daddr_nxt = dld ? dbase : (w_dstep ? r_daddr + 21'd1 : r_daddr);
  assign w_dleft_nxt = dld ? dcnt
                     : ((w_dstep && (r_dleft != 8'd0)) ? r_dleft - 8'd1 : r_dleft);
  assign w_rcnt_nxt  = w_rinc ? r_rcnt + 8'd1 : r_rcnt;
  assign w_ddone_nxt = !dld && w_dstep && (r_dleft == 8'd1);

  always_comb begin
    w_own_nxt  = c_OWN_IDLE;
    w_addr_nxt = 21'd0;
    if (r_rpend || refr) begin
      w_own_nxt  = c_OWN_REF;
      w_addr_nxt = {13'd0, w_rcnt_nxt};
    end else if (vreq) begin
      w_own_nxt  = c_OWN_VID;
      w_addr_nxt = w_vaddr_nxt;
    end else if (dreq && (w_dleft_nxt != 8'd0)) begin
      w_own_nxt  = c_OWN_DMA;
      w_addr_nxt = w_daddr_nxt;
    end
  end

  always_ff @(posedge c or negedge xr) begin
    if (!xr) begin
      r_phase <= 2'd0;
      r_own   <= c_OWN_IDLE;
      r_cyc   <= 1'b0;
      r_addr  <= 21'd0;
      r_vaddr <= 21'd0;
      r_daddr <= 21'd0;
      r_dleft <= 8'd0;
      r_ddone <= 1'b0;
      r_rcnt  <= 8'd0;
      r_rpend <= 1'b0;
    end else begin
      r_phase <= r_phase + 2'd1;
      r_vaddr <= w_vaddr_nxt;
      r_daddr <= w_daddr_nxt;
      r_dleft <= w_dleft_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_ddone <= w_ddone_nxt;
      // A refr arriving on the granting edge is served by that grant.
      if (w_slot_end && (w_own_nxt == c_OWN_REF)) begin
        r_rpend <= 1'b0;
      end else begin
        r_rpend <= r_rpend | refr;
      end
      if (w_slot_end) begin
        r_own  <= w_own_nxt;
        r_addr <= w_addr_nxt;
        r_cyc  <= (w_own_nxt != c_OWN_IDLE);
      end
    end
  end

  assign addr  = r_addr;
  assign cyc   = r_cyc;
  assign own   = r_own;
  assign vaddr = r_vaddr;
  assign daddr = r_daddr;
  assign dleft = r_dleft;
  assign ddone = r_ddone;
  assign rcnt  = r_rcnt;

endmodule

`default_nettype wire

// File: tb/tb_adrctl.sv
// tb_adrctl: directed self-checking bench for adrctl slot arbitration and counters.
`default_nettype none

module tb_adrctl;

  logic        c;
  logic        xr;
  logic        vld;
  logic [20:0] vbase;
  logic        vreq;
  logic        dld;
  logic [20:0] dbase;
  logic [7:0]  dcnt;
  logic        dreq;
  logic        refr;
  logic [20:0] addr;
  logic        cyc;
  logic [1:0]  own;
  logic [20:0] vaddr;
  logic [20:0] daddr;
  logic [7:0]  dleft;
  logic        ddone;
  logic [7:0]  rcnt;

  int n_tests;
  int n_fail;

  adrctl u_dut (
    .c     (c),
    .xr    (xr),
    .vld   (vld),
    .vbase (vbase),
    .vreq  (vreq),
    .dld   (dld),
    .dbase (dbase),
    .dcnt  (dcnt),
    .dreq  (dreq),
    .refr  (refr),
    .addr  (addr),
    .cyc   (cyc),
    .own   (own),
    .vaddr (vaddr),
    .daddr (daddr),
    .dleft (dleft),
    .ddone (ddone),
    .rcnt  (rcnt)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge c);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    xr    = 1'b0;
    vld   = 1'b1;
    vbase = 21'h001000;
    vreq  = 1'b1;
    dld   = 1'b0;
    dbase = 21'd0;
    dcnt  = 8'd0;
    dreq  = 1'b0;
    refr  = 1'b0;

    // Reset state, with loads requested to prove reset dominates
    repeat (2) @(posedge c);
    @(negedge c);
    check("rst_own",   32'(own),   32'h0);
    check("rst_cyc",   32'(cyc),   32'h0);
    check("rst_addr",  32'(addr),  32'h0);
    check("rst_vaddr", 32'(vaddr), 32'h0);
    check("rst_daddr", 32'(daddr), 32'h0);
    check("rst_dleft", 32'(dleft), 32'h0);
    check("rst_rcnt",  32'(rcnt),  32'h0);
    check("rst_ddone", 32'(ddone), 32'h0);

    // Video start: first grant on the 4th edge after release
    xr = 1'b1;
    tick(1);
    vld = 1'b0;
    tick(2);
    check("v_pre_own", 32'(own), 32'h0);
    check("v_pre_cyc", 32'(cyc), 32'h0);
    tick(1);
    check("v1_own",  32'(own),  32'h1);
    check("v1_cyc",  32'(cyc),  32'h1);
    check("v1_addr", 32'(addr), 32'h001000);
    tick(4);
    check("v2_addr",  32'(addr),  32'h001001);
    check("v2_vaddr", 32'(vaddr), 32'h001001);

    // Load at the slot-ending edge overrides the increment
    tick(3);
    vld   = 1'b1;
    vbase = 21'h000200;
    tick(1);
    vld = 1'b0;
    check("vld_vaddr", 32'(vaddr), 32'h000200);
    check("vld_addr",  32'(addr),  32'h000200);
    check("vld_own",   32'(own),   32'h1);

    // Mid-slot reload leaves the in-progress address alone
    vld   = 1'b1;
    vbase = 21'h000300;
    tick(1);
    vld = 1'b0;
    check("mid_addr",  32'(addr),  32'h000200);
    check("mid_vaddr", 32'(vaddr), 32'h000300);
    tick(3);
    check("mid_next", 32'(addr), 32'h000301);

    // Priority: refresh > video > DMA
    dld   = 1'b1;
    dbase = 21'h000050;
    dcnt  = 8'd5;
    dreq  = 1'b1;
    refr  = 1'b1;
    tick(1);
    dld  = 1'b0;
    refr = 1'b0;
    tick(3);
    check("pri_ref_own",  32'(own),  32'h3);
    check("pri_ref_addr", 32'(addr), 32'h0);
    tick(4);
    check("pri_v_own",  32'(own),  32'h1);
    check("pri_v_addr", 32'(addr), 32'h000302);
    check("pri_rcnt",   32'(rcnt), 32'h1);
    tick(4);
    check("pri_v2_own", 32'(own),   32'h1);
    check("pri_daddr",  32'(daddr), 32'h000050);
    check("pri_dleft",  32'(dleft), 32'h5);

    // DMA run with address wrap and completion pulse
    vreq  = 1'b0;
    dld   = 1'b1;
    dbase = 21'h1FFFFE;
    dcnt  = 8'd3;
    tick(1);
    dld = 1'b0;
    tick(3);
    check("d1_own",  32'(own),  32'h2);
    check("d1_addr", 32'(addr), 32'h1FFFFE);
    tick(4);
    check("d2_addr",  32'(addr),  32'h1FFFFF);
    check("d2_dleft", 32'(dleft), 32'h2);
    tick(4);
    check("d3_addr",  32'(addr),  32'h000000);
    check("d3_own",   32'(own),   32'h2);
    check("d3_ddone", 32'(ddone), 32'h0);
    tick(4);
    check("dend_ddone", 32'(ddone), 32'h1);
    check("dend_dleft", 32'(dleft), 32'h0);
    check("dend_own",   32'(own),   32'h0);
    check("dend_cyc",   32'(cyc),   32'h0);
    tick(1);
    check("dend_ddone_off", 32'(ddone), 32'h0);

    // 256 refresh grants starting from row 1; the last one lands on row 0
    dreq = 1'b0;
    refr = 1'b1;
    tick(3);
    check("r1_own",  32'(own),  32'h3);
    check("r1_addr", 32'(addr), 32'h1);
    tick(4 * 254);
    check("r255_rcnt", 32'(rcnt), 32'hFF);
    check("r255_addr", 32'(addr), 32'hFF);
    tick(4);
    check("rwrap_rcnt", 32'(rcnt), 32'h0);
    check("rwrap_addr", 32'(addr), 32'h0);
    check("rwrap_own",  32'(own),  32'h3);
    refr = 1'b0;

    // Asynchronous reset in phase 2 of a DMA slot
    dld   = 1'b1;
    dbase = 21'h000100;
    dcnt  = 8'd4;
    dreq  = 1'b1;
    tick(1);
    dld = 1'b0;
    tick(3);
    check("ar_pre_own",  32'(own),  32'h2);
    check("ar_pre_addr", 32'(addr), 32'h000100);
    tick(2);
    #2;
    xr = 1'b0;
    #1;
    check("ar_own",   32'(own),   32'h0);
    check("ar_cyc",   32'(cyc),   32'h0);
    check("ar_addr",  32'(addr),  32'h0);
    check("ar_vaddr", 32'(vaddr), 32'h0);
    check("ar_daddr", 32'(daddr), 32'h0);
    check("ar_dleft", 32'(dleft), 32'h0);
    check("ar_rcnt",  32'(rcnt),  32'h0);
    check("ar_ddone", 32'(ddone), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
